// File: rtl/reg_wr_arbiter.sv
// Two-requester writeback arbiter for the register-file write port.
// Optional pend_mask scoreboard output when RWA_PEND_EN is defined.
module reg_wr_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p0_valid,
  output logic                     p0_ready,
  input  logic [4:0]               p0_addr,
  input  logic [31:0]              p0_data,
  input  logic                     p1_valid,
  output logic                     p1_ready,
  input  logic [4:0]               p1_addr,
  input  logic [31:0]              p1_data,
  output logic                     RegWr,
  output logic [4:0]               Rw,
  output logic [31:0]              busW,
  output logic [$clog2(DEPTH):0]   pending,
`ifdef RWA_PEND_EN
  output logic [31:0]              pend_mask,
`endif
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]  addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          regwr_q;
  logic [4:0]    rw_q;
  logic [31:0]   busw_q;

  logic        frc, nonempty;
  logic        push, pop, take0;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;

  assign nonempty = (cnt_q != '0);
  assign frc      = nonempty && (starve_q == SW'(STARVE_LIMIT));
  assign p0_ready = !frc;
  assign p1_ready = (cnt_q < (AW+1)'(DEPTH));

  assign push  = p1_valid && p1_ready;
  assign pop   = frc || (!p0_valid && nonempty);
  assign take0 = !frc && p0_valid;

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    unique case (1'b1)
      pop:     begin
        gnt_addr = addr_q[rd_ptr_q];
        gnt_data = data_q[rd_ptr_q];
      end
      take0:   begin
        gnt_addr = p0_addr;
        gnt_data = p0_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // Counter only runs while p1 work is actually waiting behind p0
  always_comb begin
    starve_d = starve_q;
    if (pop || !nonempty) begin
      starve_d = '0;
    end else if (take0 && starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      regwr_q  <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= p1_addr;
        data_q[wr_ptr_q] <= p1_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      regwr_q  <= 1'b0;
      if (pop || take0) begin
        rw_q    <= gnt_addr;
        busw_q  <= gnt_data;
        regwr_q <= (gnt_addr != 5'd0);
      end
    end
  end

  assign RegWr   = regwr_q;
  assign Rw      = rw_q;
  assign busW    = busw_q;
  assign pending = cnt_q;
  assign busy    = nonempty || regwr_q;

`ifdef RWA_PEND_EN
  logic [AW-1:0] idx [DEPTH];

  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx[k] = rd_ptr_q + AW'(k);
      if ((AW+1)'(k) < cnt_q) pend_mask[addr_q[idx[k]]] = 1'b1;
    end
    if (regwr_q) pend_mask[rw_q] = 1'b1;
    pend_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Directed vectors; a negedge monitor retires expected writes.
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [4:0]  p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data;
  logic        RegWr, busy;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [1:0]  pending;
`ifdef RWA_PEND_EN
  logic [31:0] pend_mask;
`endif

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  reg_wr_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_valid (p0_valid),
    .p0_ready (p0_ready),
    .p0_addr  (p0_addr),
    .p0_data  (p0_data),
    .p1_valid (p1_valid),
    .p1_ready (p1_ready),
    .p1_addr  (p1_addr),
    .p1_data  (p1_data),
    .RegWr    (RegWr),
    .Rw       (Rw),
    .busW     (busW),
    .pending  (pending),
`ifdef RWA_PEND_EN
    .pend_mask(pend_mask),
`endif
    .busy     (busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a,
                           input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every register-file write must match the queue head
  always @(negedge clk) begin
    if (rst === 1'b1 && RegWr === 1'b1) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got Rw=%0d busW=%h expected no write",
                 Rw, busW);
      end else begin
        e = exp_q.pop_front();
        if ({Rw, busW} !== e) begin
          errors++;
          $display("FAIL sb_write: got Rw=%0d busW=%h expected Rw=%0d busW=%h",
                   Rw, busW, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int k;
    p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
    p1_valid = 1'b0; p1_addr = '0; p1_data = '0;

    // 1: reset with p0 requesting
    rst = 1'b0;
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'hDEADBEEF;
    repeat (3) step();
    chk("rst_regwr",   32'(RegWr),    32'd0);
    chk("rst_pending", 32'(pending),  32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_p1rdy",   32'(p1_ready), 32'd1);
    rst = 1'b1;
    chk("t1_p0rdy", 32'(p0_ready), 32'd1);
    expect_wr(5'd5, 32'hDEADBEEF);
    step();
    p0_valid = 1'b0;
    chk("t1_regwr", 32'(RegWr), 32'd1);
    chk("t1_rw",    32'(Rw),    32'd5);
    chk("t1_busw",  busW,       32'hDEADBEEF);
    step();

    // 2: p1 alone, two-cycle latency
    p1_valid = 1'b1; p1_addr = 5'd7; p1_data = 32'h1234;
    chk("t2_p1rdy", 32'(p1_ready), 32'd1);
    expect_wr(5'd7, 32'h1234);
    step();
    p1_valid = 1'b0;
    chk("t2_nobypass", 32'(RegWr),   32'd0);
    chk("t2_pend1",    32'(pending), 32'd1);
    step();
    chk("t2_regwr", 32'(RegWr),   32'd1);
    chk("t2_rw",    32'(Rw),      32'd7);
    chk("t2_pend0", 32'(pending), 32'd0);
    step();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_hold_rw",   32'(Rw),   32'd7);
    chk("t2_hold_busw", busW,      32'h1234);

    // 3: starvation forces p1 after four p0 grants
    p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'hA5A5;
    step();
    p1_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      p0_valid = 1'b1;
      p0_addr  = 5'(10 + k);
      p0_data  = 32'h100 + 32'(k);
      chk($sformatf("t3_p0rdy_c%0d", c), 32'(p0_ready),
          (c == 4) ? 32'd0 : 32'd1);
      if (c == 4) begin
        expect_wr(5'd9, 32'hA5A5);
      end else begin
        expect_wr(5'(10 + k), 32'h100 + 32'(k));
        k++;
      end
      step();
    end
    p0_valid = 1'b0;
    step();
    chk("t3_pend0", 32'(pending), 32'd0);

    // 4: fill the FIFO while p0 is busy
    p0_valid = 1'b1; p0_addr = 5'd20; p0_data = 32'h2000;
    p1_valid = 1'b1; p1_addr = 5'd21; p1_data = 32'h2100;
    expect_wr(5'd20, 32'h2000);
    step();
    p0_addr = 5'd22; p0_data = 32'h2200;
    p1_addr = 5'd23; p1_data = 32'h2300;
    chk("t4_p1rdy1", 32'(p1_ready), 32'd1);
    expect_wr(5'd22, 32'h2200);
    step();
    p0_addr = 5'd24; p0_data = 32'h2400;
    p1_addr = 5'd25; p1_data = 32'h2500;
    chk("t4_full_rdy",  32'(p1_ready), 32'd0);
    chk("t4_full_pend", 32'(pending),  32'd2);
    expect_wr(5'd24, 32'h2400);
    step();
    p0_valid = 1'b0; p1_valid = 1'b0;
    expect_wr(5'd21, 32'h2100);
    expect_wr(5'd23, 32'h2300);
    repeat (3) step();
    chk("t4_pend0", 32'(pending), 32'd0);

    // 5: write to $zero is consumed silently
    p0_valid = 1'b1; p0_addr = 5'd0; p0_data = 32'hFFFFFFFF;
    chk("t5_p0rdy", 32'(p0_ready), 32'd1);
    step();
    p0_addr = 5'd3; p0_data = 32'h33;
    chk("t5_zero_regwr", 32'(RegWr), 32'd0);
`ifdef RWA_PEND_EN
    chk("t5_mask0", pend_mask, 32'd0);
`endif
    expect_wr(5'd3, 32'h33);
    step();
    p0_valid = 1'b0;
    chk("t5_next_regwr", 32'(RegWr), 32'd1);
    chk("t5_next_busw",  busW,       32'h33);
    step();

    // 6: async reset with two entries buffered
    p0_valid = 1'b1; p0_addr = 5'd1; p0_data = 32'h6100;
    p1_valid = 1'b1; p1_addr = 5'd2; p1_data = 32'h6200;
    expect_wr(5'd1, 32'h6100);
    step();
    p0_addr = 5'd4; p0_data = 32'h6400;
    p1_addr = 5'd6; p1_data = 32'h6600;
    expect_wr(5'd4, 32'h6400);
    step();
    p0_valid = 1'b0; p1_valid = 1'b0;
    chk("t6_pend2", 32'(pending), 32'd2);
`ifdef RWA_PEND_EN
    chk("t6_mask", pend_mask, 32'h0000_0054);
`endif
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_async_pend",  32'(pending), 32'd0);
    chk("t6_async_regwr", 32'(RegWr),   32'd0);
    chk("t6_async_busy",  32'(busy),    32'd0);
    repeat (2) step();
    rst = 1'b1;
    repeat (5) step();
    chk("t6_after_pend", 32'(pending), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
